// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if -- bundle of the write-path and transmitter-handshake
// signals of uart_tx_buffer.
//   slave  : the buffer itself (takes writes, drives the transmitter request)
//   master : the surrounding logic (CPU write path + UART transmitter)
// Signals: wr_en/wr_data (write strobe, byte), full/empty/count (fill state),
// busy, tx_start/d_tx (request + byte to transmitter), tx_done (from
// transmitter), overflow/ovf_clr (sticky drop flag and its clear).
interface uart_tx_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          busy;
  logic          tx_start;
  logic [7:0]    d_tx;
  logic          tx_done;
  logic          overflow;
  logic          ovf_clr;

  modport slave (
    input  wr_en, wr_data, tx_done, ovf_clr,
    output full, empty, count, busy, tx_start, d_tx, overflow
  );

  modport master (
    output wr_en, wr_data, tx_done, ovf_clr,
    input  full, empty, count, busy, tx_start, d_tx, overflow
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer -- DEPTH-entry byte FIFO plus sequencer feeding a UART
// transmitter over a tx_start/d_tx/tx_done handshake.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : uart_tx_buffer_if.slave (write path, fill state, transmitter
//              handshake, overflow flag)
// Build option: define UART_TX_BUF_OVF_EN to build the sticky overflow flag;
// otherwise overflow is tied low and ovf_clr is ignored.
module uart_tx_buffer #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_buffer_if.slave   bus
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RELEASE
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic [7:0]    d_tx_q;
  logic          full_c, empty_c;
  logic          wr_ok, pop, tx_start_c;

  assign full_c  = (cnt == FULL_CNT);
  assign empty_c = (cnt == '0);
  assign wr_ok   = bus.wr_en && !full_c;

  // Sequencer: IDLE pops a byte and requests; SEND holds the request until
  // the transmitter reaches its stop state; RELEASE waits for it to leave.
  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    tx_start_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty_c) begin
          pop      = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        tx_start_c = 1'b1;
        if (bus.tx_done) state_nx = RELEASE;
      end
      RELEASE: begin
        if (!bus.tx_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Storage array carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      d_tx_q <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (pop) begin
        d_tx_q <= mem[rp];
        rp     <= rp + 1'b1;
      end
      unique case ({wr_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef UART_TX_BUF_OVF_EN
  logic ovf_q;

  // Set has priority over clear when both happen in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  ovf_q <= 1'b0;
    else if (bus.wr_en && full_c)  ovf_q <= 1'b1;
    else if (bus.ovf_clr)          ovf_q <= 1'b0;
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.count    = cnt;
  assign bus.busy     = (state != IDLE);
  assign bus.tx_start = tx_start_c;
  assign bus.d_tx     = d_tx_q;

endmodule
